// File: rtl/kyber_bf_pkg.sv
// Shared definitions for the Kyber butterfly datapath: mode encodings, the default
// modulus, Barrett constant derivation and the exact modular halving helper.
package kyber_bf_pkg;

    typedef enum logic [1:0] {
        BF_NTT  = 2'b00,
        BF_INTT = 2'b01,
        BF_BYP  = 2'b10,
        BF_MUL  = 2'b11
    } bf_mode_t;

    localparam int BF_Q_DEFAULT = 3329;

    function automatic int bf_barrett_k(input int q);
        return 2 * $clog2(q);
    endfunction

    function automatic int bf_barrett_m(input int q);
        return int'((longint'(1) << bf_barrett_k(q)) / longint'(q));
    endfunction

    // x * 2^-1 mod q for odd q and x < q: an odd x is made even by adding q first.
    function automatic logic [31:0] bf_half(input logic [31:0] x, input logic [31:0] q);
        return x[0] ? ((x + q) >> 1) : (x >> 1);
    endfunction

endpackage

// File: rtl/butterfly_pipe_if.sv
// Sample-in / result-out stream bundle of the butterfly pipe.
interface butterfly_pipe_if
    import kyber_bf_pkg::*;
#(
    parameter int DW = 16
);
    // Both directions: a beat moves when valid and ready are high on the same rising
    // edge; valid and its payload must hold until that edge, ready may change freely.
    logic          in_valid;
    logic          in_ready;
    bf_mode_t      mode;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] w;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] c;
    logic [DW-1:0] d;

    modport master (
        output in_valid, mode, a, b, w, out_ready,
        input  in_ready, out_valid, c, d
    );

    modport slave (
        input  in_valid, mode, a, b, w, out_ready,
        output in_ready, out_valid, c, d
    );

endinterface

// File: rtl/bf_barrett_pipe.sv
// Barrett reduction of a 2*DW-bit value below Q^2 to [0, Q), STAGES register stages deep,
// all stages advancing only while en is high.
module bf_barrett_pipe
    import kyber_bf_pkg::*;
#(
    parameter int DW     = 16,
    parameter int Q      = BF_Q_DEFAULT,
    parameter int STAGES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [2*DW-1:0] x,
    output logic [DW-1:0]   r
);

    localparam int K  = bf_barrett_k(Q);
    localparam int M  = bf_barrett_m(Q);
    localparam int PW = 2 * DW + K + 1;
    localparam logic [2*DW-1:0] QW = (2 * DW)'(Q);

    logic [PW-1:0]   xm;
    logic [2*DW-1:0] qe;
    logic [2*DW-1:0] x_s;
    logic [2*DW-1:0] qe_s;
    logic [2*DW-1:0] r0;
    logic [2*DW-1:0] r1;
    logic [2*DW-1:0] r2;

    assign xm = PW'(x) * PW'(M);
    assign qe = (2 * DW)'(xm >> K);

    // With two stages the quotient estimate is registered before the back-multiply.
    generate
        if (STAGES >= 2) begin : g_pre
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    x_s  <= '0;
                    qe_s <= '0;
                end else if (en) begin
                    x_s  <= x;
                    qe_s <= qe;
                end
            end
        end else begin : g_comb
            assign x_s  = x;
            assign qe_s = qe;
        end
    endgenerate

    // The estimate undershoots the true quotient by at most two.
    always_comb begin
        r0 = x_s - qe_s * QW;
        r1 = (r0 >= QW) ? (r0 - QW) : r0;
        r2 = (r1 >= QW) ? (r1 - QW) : r1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r <= '0;
        end else if (en) begin
            r <= DW'(r2);
        end
    end

endmodule

// File: rtl/butterfly_pipe.sv
// Pipelined Kyber butterfly: CT NTT, GS INTT with optional halving, bypass and pointwise
// multiply. A stalled output freezes every stage at once.
module butterfly_pipe
    import kyber_bf_pkg::*;
#(
    parameter int DW         = 16,
    parameter int Q          = BF_Q_DEFAULT,
    parameter int MUL_STAGES = 1,
    parameter int RED_STAGES = 1,
    parameter int HALVE_INTT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    butterfly_pipe_if.slave      bus,
    output logic                 busy
);

    localparam int MID = MUL_STAGES + RED_STAGES;
    localparam logic [DW:0]   QX = (DW + 1)'(Q);
    localparam logic [31:0]   Q32 = 32'(Q);

    logic stall;
    logic en;

    assign stall        = bus.out_valid & ~bus.out_ready;
    assign en           = ~stall;
    assign bus.in_ready = ~stall;

    // Stage 0 pre-ops: INTT sum/difference and multiplier operand selection.
    logic [DW:0]   sum_ab;
    logic [DW:0]   dif_ba;
    logic [DW-1:0] s_mod;
    logic [DW-1:0] e_mod;
    logic [DW-1:0] mx;
    logic [DW-1:0] my;
    logic [DW-1:0] aux0;
    logic [DW-1:0] aux1;

    always_comb begin
        sum_ab = {1'b0, bus.a} + {1'b0, bus.b};
        dif_ba = {1'b0, bus.b} - {1'b0, bus.a};
        s_mod  = (sum_ab >= QX) ? DW'(sum_ab - QX) : DW'(sum_ab);
        e_mod  = dif_ba[DW] ? DW'(dif_ba + QX) : DW'(dif_ba);
        mx     = '0;
        my     = '0;
        aux0   = bus.a;
        aux1   = '0;
        case (bus.mode)
            BF_NTT: begin
                mx = bus.b;
                my = bus.w;
            end
            BF_INTT: begin
                mx   = e_mod;
                my   = bus.w;
                aux0 = s_mod;
            end
            BF_BYP: begin
                aux1 = bus.b;
            end
            BF_MUL: begin
                mx = bus.a;
                my = bus.b;
            end
            default: ;
        endcase
    end

    logic          v0;
    bf_mode_t      m0;
    logic [DW-1:0] x0;
    logic [DW-1:0] y0;
    logic [DW-1:0] p0a;
    logic [DW-1:0] p0b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v0  <= 1'b0;
            m0  <= BF_NTT;
            x0  <= '0;
            y0  <= '0;
            p0a <= '0;
            p0b <= '0;
        end else if (en) begin
            v0  <= bus.in_valid;
            m0  <= bus.mode;
            x0  <= mx;
            y0  <= my;
            p0a <= aux0;
            p0b <= aux1;
        end
    end

    logic [2*DW-1:0] prod;
    logic [2*DW-1:0] mul_q [MUL_STAGES];

    assign prod = (2 * DW)'(x0) * (2 * DW)'(y0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MUL_STAGES; i++) mul_q[i] <= '0;
        end else if (en) begin
            mul_q[0] <= prod;
            for (int i = 1; i < MUL_STAGES; i++) mul_q[i] <= mul_q[i-1];
        end
    end

    logic [DW-1:0] t_red;

    bf_barrett_pipe #(
        .DW     (DW),
        .Q      (Q),
        .STAGES (RED_STAGES)
    ) u_red (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .x   (mul_q[MUL_STAGES-1]),
        .r   (t_red)
    );

    // Side channel: valid, mode and the non-multiplied operands ride alongside multiplier and reducer.
    logic [MID-1:0] sv;
    bf_mode_t       sm  [MID];
    logic [DW-1:0]  sa0 [MID];
    logic [DW-1:0]  sa1 [MID];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sv <= '0;
            for (int i = 0; i < MID; i++) begin
                sm[i]  <= BF_NTT;
                sa0[i] <= '0;
                sa1[i] <= '0;
            end
        end else if (en) begin
            sv[0]  <= v0;
            sm[0]  <= m0;
            sa0[0] <= p0a;
            sa1[0] <= p0b;
            for (int i = 1; i < MID; i++) begin
                sv[i]  <= sv[i-1];
                sm[i]  <= sm[i-1];
                sa0[i] <= sa0[i-1];
                sa1[i] <= sa1[i-1];
            end
        end
    end

    logic [DW:0]   sum_at;
    logic [DW:0]   dif_at;
    logic [DW-1:0] hs;
    logic [DW-1:0] hp;
    logic [DW-1:0] c_nxt;
    logic [DW-1:0] d_nxt;

    always_comb begin
        sum_at = {1'b0, sa0[MID-1]} + {1'b0, t_red};
        dif_at = {1'b0, sa0[MID-1]} - {1'b0, t_red};
        hs     = (HALVE_INTT != 0) ? DW'(bf_half(32'(sa0[MID-1]), Q32)) : sa0[MID-1];
        hp     = (HALVE_INTT != 0) ? DW'(bf_half(32'(t_red), Q32)) : t_red;
        c_nxt  = '0;
        d_nxt  = '0;
        case (sm[MID-1])
            BF_NTT: begin
                c_nxt = (sum_at >= QX) ? DW'(sum_at - QX) : DW'(sum_at);
                d_nxt = dif_at[DW] ? DW'(dif_at + QX) : DW'(dif_at);
            end
            BF_INTT: begin
                c_nxt = hs;
                d_nxt = hp;
            end
            BF_BYP: begin
                c_nxt = sa0[MID-1];
                d_nxt = sa1[MID-1];
            end
            BF_MUL: begin
                c_nxt = t_red;
            end
            default: ;
        endcase
    end

    logic          out_valid_q;
    logic [DW-1:0] c_q;
    logic [DW-1:0] d_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            c_q         <= '0;
            d_q         <= '0;
        end else if (en) begin
            out_valid_q <= sv[MID-1];
            c_q         <= c_nxt;
            d_q         <= d_nxt;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.c         = c_q;
    assign bus.d         = d_q;
    assign busy          = v0 | (|sv) | out_valid_q;

endmodule

// File: tb/tb_butterfly_pipe.sv
// Bench for butterfly_pipe: a default instance under full handshake, plus a no-halving
// instance and a deep-pipeline instance fed the same input stream with a free output.
module tb_butterfly_pipe;
    import kyber_bf_pkg::*;

    localparam int DW = 16;
    localparam int Q  = 3329;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    butterfly_pipe_if #(.DW(DW)) bif ();
    butterfly_pipe_if #(.DW(DW)) if_h0 ();
    butterfly_pipe_if #(.DW(DW)) if_m3 ();
    logic busy, busy_h0, busy_m3;

    butterfly_pipe #(.DW(DW), .Q(Q), .MUL_STAGES(1), .RED_STAGES(1), .HALVE_INTT(1)) dut (
        .clk(clk), .rst(rst), .bus(bif), .busy(busy));
    butterfly_pipe #(.DW(DW), .Q(Q), .MUL_STAGES(1), .RED_STAGES(1), .HALVE_INTT(0)) dut_h0 (
        .clk(clk), .rst(rst), .bus(if_h0), .busy(busy_h0));
    butterfly_pipe #(.DW(DW), .Q(Q), .MUL_STAGES(3), .RED_STAGES(2), .HALVE_INTT(1)) dut_m3 (
        .clk(clk), .rst(rst), .bus(if_m3), .busy(busy_m3));

    assign if_h0.in_valid  = bif.in_valid;
    assign if_h0.mode      = bif.mode;
    assign if_h0.a         = bif.a;
    assign if_h0.b         = bif.b;
    assign if_h0.w         = bif.w;
    assign if_h0.out_ready = 1'b1;
    assign if_m3.in_valid  = bif.in_valid;
    assign if_m3.mode      = bif.mode;
    assign if_m3.a         = bif.a;
    assign if_m3.b         = bif.b;
    assign if_m3.w         = bif.w;
    assign if_m3.out_ready = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out0   = 0;

    logic [2*DW-1:0] exp_q0[$];
    logic [2*DW-1:0] exp_q1[$];
    logic [2*DW-1:0] exp_q2[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int half_ref(input int x);
        return (x % 2 == 0) ? x / 2 : (x + Q) / 2;
    endfunction

    // Reference butterfly straight from the modular arithmetic definitions.
    function automatic logic [2*DW-1:0] ref_bf(input logic [1:0] m, input int a, input int b,
                                               input int w, input bit halve);
        int t, s, e, p, c, d;
        c = 0;
        d = 0;
        case (m)
            2'd0: begin
                t = (b * w) % Q;
                c = (a + t) % Q;
                d = (a - t + Q) % Q;
            end
            2'd1: begin
                s = (a + b) % Q;
                e = (b - a + Q) % Q;
                p = (e * w) % Q;
                c = halve ? half_ref(s) : s;
                d = halve ? half_ref(p) : p;
            end
            2'd2: begin
                c = a;
                d = b;
            end
            default: begin
                c = (a * b) % Q;
                d = 0;
            end
        endcase
        return {DW'(c), DW'(d)};
    endfunction

    // Scoreboard: sampled on the falling edge, transfers happen at the following rising edge.
    logic            held_prev = 1'b0;
    logic [2*DW:0]   held_val  = '0;
    logic [2*DW-1:0] e_pop;

    always @(negedge clk) begin
        if (!rst) begin
            held_prev = 1'b0;
        end else begin
            if (bif.in_valid && bif.in_ready) begin
                assert (bif.a < Q && bif.b < Q && bif.w < Q)
                    else $error("FAIL in_range: a=%0d b=%0d w=%0d not below %0d", bif.a, bif.b, bif.w, Q);
                exp_q0.push_back(ref_bf(bif.mode, int'(bif.a), int'(bif.b), int'(bif.w), 1'b1));
            end
            if (if_h0.in_valid && if_h0.in_ready)
                exp_q1.push_back(ref_bf(bif.mode, int'(bif.a), int'(bif.b), int'(bif.w), 1'b0));
            if (if_m3.in_valid && if_m3.in_ready)
                exp_q2.push_back(ref_bf(bif.mode, int'(bif.a), int'(bif.b), int'(bif.w), 1'b1));
            check("in_ready", 64'(bif.in_ready), 64'(!(bif.out_valid && !bif.out_ready)));
            if (held_prev)
                check("hold_out", 64'({bif.out_valid, bif.c, bif.d}), 64'(held_val));
            held_prev = bif.out_valid & ~bif.out_ready;
            held_val  = {bif.out_valid, bif.c, bif.d};
            if (bif.out_valid && bif.out_ready) begin
                n_out0++;
                if (exp_q0.size() == 0) check("dut_spurious", 64'(1), 64'(0));
                else begin
                    e_pop = exp_q0.pop_front();
                    check("dut_cd", 64'({bif.c, bif.d}), 64'(e_pop));
                end
            end
            if (if_h0.out_valid) begin
                if (exp_q1.size() == 0) check("h0_spurious", 64'(1), 64'(0));
                else begin
                    e_pop = exp_q1.pop_front();
                    check("h0_cd", 64'({if_h0.c, if_h0.d}), 64'(e_pop));
                end
            end
            if (if_m3.out_valid) begin
                if (exp_q2.size() == 0) check("m3_spurious", 64'(1), 64'(0));
                else begin
                    e_pop = exp_q2.pop_front();
                    check("m3_cd", 64'({if_m3.c, if_m3.d}), 64'(e_pop));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input int a, input int b, input int w);
        bif.in_valid = v;
        bif.mode     = bf_mode_t'(m);
        bif.a        = DW'(a);
        bif.b        = DW'(b);
        bif.w        = DW'(w);
    endtask

    // One isolated sample with a free output; reports latency and both instances' results.
    task automatic send_one(input logic [1:0] m, input int a, input int b, input int w,
                            output int lat, output logic [2*DW-1:0] r, output logic [2*DW-1:0] r_h0);
        bif.out_ready = 1'b1;
        drive(1'b1, m, a, b, w);
        tick();
        bif.in_valid = 1'b0;
        lat = 1;
        while (!bif.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        r    = {bif.c, bif.d};
        r_h0 = {if_h0.c, if_h0.d};
        tick();
    endtask

    task automatic drain(input int limit);
        int cyc;
        cyc = 0;
        bif.in_valid = 1'b0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0 || exp_q2.size() != 0) && cyc < limit) begin
            bif.out_ready = ($urandom_range(0, 3) != 0);
            tick();
            cyc++;
        end
        bif.out_ready = 1'b1;
        check("drain_q0", 64'(exp_q0.size()), 64'(0));
        check("drain_q1", 64'(exp_q1.size()), 64'(0));
        check("drain_q2", 64'(exp_q2.size()), 64'(0));
        repeat (10) tick();
    endtask

    initial begin
        int lat, i, cyc, sent, out_before;
        logic acc, v;
        logic [2*DW-1:0] r, r_h0;
        logic pat [4];
        logic [1:0] s_m [16];
        int s_a [16], s_b [16], s_w [16];

        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        drive(1'b0, 2'd0, 0, 0, 0);
        bif.out_ready = 1'b1;
        repeat (3) tick();
        check("rst_out_valid", 64'(bif.out_valid), 64'(0));
        check("rst_c", 64'(bif.c), 64'(0));
        check("rst_d", 64'(bif.d), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_in_ready", 64'(bif.in_ready), 64'(1));
        rst = 1'b1;
        tick();

        send_one(2'd0, 100, 2, 17, lat, r, r_h0);
        check("ntt1_lat", 64'(lat), 64'(4));
        check("ntt1_cd", 64'(r), 64'({16'd134, 16'd66}));
        send_one(2'd0, 3000, 1000, 1000, lat, r, r_h0);
        check("ntt2_cd", 64'(r), 64'({16'd971, 16'd1700}));
        send_one(2'd1, 5, 8, 1, lat, r, r_h0);
        check("intt_half_cd", 64'(r), 64'({16'd1671, 16'd1666}));
        check("intt_nohalf_cd", 64'(r_h0), 64'({16'd13, 16'd3}));
        send_one(2'd2, 1234, 56, 777, lat, r, r_h0);
        check("byp_lat", 64'(lat), 64'(4));
        check("byp_cd", 64'(r), 64'({16'd1234, 16'd56}));
        send_one(2'd3, 3328, 3328, 5, lat, r, r_h0);
        check("mul_cd", 64'(r), 64'({16'd1, 16'd0}));
        drain(100);

        // Back-to-back mixed modes against an out_ready pattern of 1,0,0,1.
        for (int k = 0; k < 16; k++) begin
            s_m[k] = 2'(k % 4);
            s_a[k] = $urandom_range(0, Q - 1);
            s_b[k] = $urandom_range(0, Q - 1);
            s_w[k] = $urandom_range(0, Q - 1);
        end
        out_before = n_out0;
        i = 0;
        cyc = 0;
        while (i < 16 && cyc < 200) begin
            drive(1'b1, s_m[i], s_a[i], s_b[i], s_w[i]);
            bif.out_ready = pat[cyc % 4];
            #1 acc = bif.in_ready;
            tick();
            if (acc) i++;
            cyc++;
        end
        check("stream_sent", 64'(i), 64'(16));
        drain(200);
        check("stream_count", 64'(n_out0 - out_before), 64'(16));

        // Reset with three samples in flight.
        bif.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 2'(k), $urandom_range(0, Q - 1), $urandom_range(0, Q - 1), $urandom_range(0, Q - 1));
            tick();
        end
        bif.in_valid = 1'b0;
        check("pre_rst_busy", 64'(busy), 64'(1));
        rst = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(bif.out_valid), 64'(0));
        check("mid_rst_busy", 64'({busy, busy_h0, busy_m3}), 64'(0));
        check("mid_rst_c", 64'(bif.c), 64'(0));
        check("mid_rst_d", 64'(bif.d), 64'(0));
        exp_q0.delete();
        exp_q1.delete();
        exp_q2.delete();
        tick();
        rst = 1'b1;
        tick();
        send_one(2'd0, 2000, 3000, 1500, lat, r, r_h0);
        check("post_rst_lat", 64'(lat), 64'(4));
        check("post_rst_cd", 64'(r), 64'(ref_bf(2'd0, 2000, 3000, 1500, 1'b1)));
        drain(100);

        // Random sweep across all modes with random bubbles and backpressure.
        sent = 0;
        cyc = 0;
        while (sent < 10000 && cyc < 40000) begin
            v = ($urandom_range(0, 9) < 8);
            drive(v, 2'($urandom_range(0, 3)), $urandom_range(0, Q - 1), $urandom_range(0, Q - 1),
                  $urandom_range(0, Q - 1));
            bif.out_ready = ($urandom_range(0, 9) < 8);
            #1 acc = v & bif.in_ready;
            tick();
            if (acc) sent++;
            cyc++;
        end
        check("sweep_sent", 64'(sent), 64'(10000));
        drain(500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/butterfly_pipe.md
Name: butterfly_pipe

Overview:
Parametrised, fully pipelined modular butterfly for the Kyber NTT datapath, generalised from the fixed 16-bit unit. It supports Cooley-Tukey NTT, Gentleman-Sande INTT with exact modular halving, bypass, and a new pointwise-multiply mode. A valid/ready handshake with whole-pipe stall lets the memory/address controller apply backpressure. The block sits between coefficient RAM read ports and the write-back path.

Parameters:
DW, 16, coefficient width; must satisfy 2^DW > 2*Q.
Q, 3329, modulus.
MUL_STAGES, 1, register stages inside the DWxDW multiplier (1..3).
RED_STAGES, 1, register stages inside the Barrett reducer (1..2).
HALVE_INTT, 1, 1 = INTT outputs multiplied by 2^-1 mod Q; 0 = no halving.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  input sample valid
in_ready  out  1  block accepts a sample this cycle
mode  in  2  00 NTT(CT), 01 INTT(GS), 10 bypass, 11 pointwise MUL; sampled with data
a  in  DW  upper coefficient, value < Q
b  in  DW  lower coefficient, value < Q
w  in  DW  twiddle, value < Q
out_valid  out  1  c/d valid
out_ready  in  1  downstream accepts
c  out  DW  result 0
d  out  DW  result 1
busy  out  1  any pipeline stage holds a valid sample

Behaviour:
- Latency L = 2 + MUL_STAGES + RED_STAGES cycles (default 4) from accepted input to out_valid, absent stalls. Throughput 1 sample/cycle.
- Stages: S0 registers inputs and computes pre-ops; then MUL_STAGES multiply, RED_STAGES Barrett reduce, and a final output-register stage with post-ops. mode, a and the valid bit travel alongside in shift registers.
- NTT: t = b*w mod Q; c = (a+t) mod Q; d = (a-t) mod Q.
- INTT: s = (a+b) mod Q and e = (b-a) mod Q at S0; p = e*w mod Q; c = half(s), d = half(p).
  - half(x) = x>>1 if x even, else (x+Q)>>1.
  - With HALVE_INTT=0: c = s, d = p.
- Bypass: c = a, d = b, unmodified, at the same latency L.
- MUL: c = a*b mod Q; d = 0.
- Barrett: k = 2*ceil(log2 Q); m = floor(2^k/Q); at most two conditional subtractions. Reducer output is always < Q.
- Modular add/sub use a DW+1-bit intermediate with one conditional correction. All non-bypass outputs are < Q.
- Handshake:
  - stall = out_valid & ~out_ready; in_ready = ~stall.
  - Transfer on in_valid & in_ready. On stall every stage holds and c/d/out_valid stay stable.
  - Bubbles (in_valid=0) propagate as invalid slots and are not compressed.
- busy = OR of all stage valid bits.
- Reset (asynchronous, active-low): all valid bits 0, c=0, d=0, out_valid=0, busy=0; in_ready=1 after reset.
  - Reset mid-operation discards all in-flight samples; no partial output is emitted.
- Inputs ≥ Q are illegal; outputs for them are undefined, and the bench asserts this never occurs.
- mode may change every cycle; each sample uses its own captured mode.

Decomposition:
- Shared package kyber_bf_pkg holds:
  - mode encodings (BF_NTT, BF_INTT, BF_BYP, BF_MUL)
  - default Q
  - derivation functions for Barrett k and m
  - the half() function
- One sub-module, bf_barrett_pipe (input 2*DW, output DW, RED_STAGES deep, with enable), shared with the future pointwise unit.
- The multiplier is inline.

Test Plan:
- NTT, a=100, b=2, w=17 → after 4 cycles c=134, d=66; then a=3000, b=1000, w=1000 → c=971, d=1700 (wrap on both).
- INTT, HALVE_INTT=1, a=5, b=8, w=1 → c=1671, d=1666; HALVE_INTT=0, same inputs → c=13, d=3.
- Bypass a=1234, b=56 → c=1234, d=56 at latency 4; MUL a=3328, b=3328 → c=1, d=0.
- Back-to-back stream of 16 mixed-mode samples with out_ready toggling 1,0,0,1,… → in_ready low exactly when stalled, outputs held stable, and all 16 results emerge in order, matching the reference model.
- Reset pulled low mid-stream with 3 samples in flight → out_valid=0, busy=0, c=d=0 immediately; after release, the first new sample appears at latency 4 with no stale data.
- Random sweep, 10k vectors with a, b, w in [0, Q-1] across all modes and MUL_STAGES ∈ {1, 3} → zero mismatches and all outputs < Q.
